// File: rtl/sonic_v1_15_eth_10g_pa_pg_before_timing_fifo_if.sv
// Stream bundle for the pause-frame-generator timing adapter.
// Upstream side: in_valid, in_data (no ready back to the source).
// Downstream side: out_valid, out_data, out_ready.
// Status: fill_level (occupancy), overflow (dropped-beat flag).
// slave  = adapter view, master = the environment driving it.
interface sonic_v1_15_eth_10g_pa_pg_before_timing_fifo_if #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH_LOG2 = 2
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DEPTH_LOG2:0]   fill_level;
  logic                  overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, fill_level, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, fill_level, overflow
  );
endinterface

// File: rtl/sonic_v1_15_eth_10g_pa_pg_before_timing_fifo.sv
// Timing adapter: valid-only source into a backpressuring sink through a
// small show-ahead FIFO. Beats arriving while full with no pop are dropped
// and flagged on overflow.
// Ports: clk, reset_n (async, active-low), bus (slave modport of
// sonic_v1_15_eth_10g_pa_pg_before_timing_fifo_if).
// Build option: SONIC_PA_PG_TA_OVERFLOW_STICKY_EN makes overflow sticky
// until reset; without it overflow is a one-cycle pulse per dropped beat.
//
// state       | meaning
// ST_EMPTY    | count == 0, out_valid low
// ST_NONEMPTY | count >= 1, head beat presented on out_data
module sonic_v1_15_eth_10g_pa_pg_before_timing_fifo #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic clk,
  input  logic reset_n,
  sonic_v1_15_eth_10g_pa_pg_before_timing_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic {ST_EMPTY, ST_NONEMPTY} state_e;

  state_e                 state_q, state_d;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d [DEPTH];

  logic out_valid;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign out_valid = (state_q == ST_NONEMPTY);
  assign full      = (count_q == FULL_CNT);
  assign pop       = out_valid & bus.out_ready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push      = bus.in_valid & (~full | pop);
  assign drop      = bus.in_valid & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    state_d = (count_d == '0) ? ST_EMPTY : ST_NONEMPTY;

`ifdef SONIC_PA_PG_TA_OVERFLOW_STICKY_EN
    overflow_d = overflow_q | drop;
`else
    overflow_d = drop;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Head entry is presented straight from storage (show-ahead); storage is
  // zeroed on reset so out_data reads 0 while held in reset.
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = mem_q[rd_ptr_q];
  assign bus.fill_level = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_sonic_v1_15_eth_10g_pa_pg_before_timing_fifo.sv
module tb_sonic_v1_15_eth_10g_pa_pg_before_timing_fifo;

`ifdef SONIC_PA_PG_TA_OVERFLOW_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   ovf_hold;
  int   exp_q[$];

  sonic_v1_15_eth_10g_pa_pg_before_timing_fifo_if #(.DATA_WIDTH(2), .DEPTH_LOG2(2)) bus ();

  sonic_v1_15_eth_10g_pa_pg_before_timing_fifo #(.DATA_WIDTH(2), .DEPTH_LOG2(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit v, input int d, input bit r);
    bus.in_valid  = v;
    bus.in_data   = d[1:0];
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a handshake seen between edges will pop at the next edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0d expected=none", bus.out_data);
      end else begin
        chk("sb_data", int'(bus.out_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    int vals[5];
    checks   = 0;
    errors   = 0;
    ovf_hold = 0;
    reset_n  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_fill", int'(bus.fill_level), 0);
    chk("rst_overflow", int'(bus.overflow), 0);

    // pass-through at one beat per cycle
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(i % 4);
      cyc(1, i % 4, 1);
      chk("pt_fill", int'(bus.fill_level), 1);
      chk("pt_out_data", int'(bus.out_data), i % 4);
      chk("pt_out_valid", int'(bus.out_valid), 1);
      chk("pt_overflow", int'(bus.overflow), 0);
    end
    cyc(0, 0, 1);
    chk("pt_end_fill", int'(bus.fill_level), 0);
    chk("pt_end_valid", int'(bus.out_valid), 0);

    // fill to full, then drain
    vals = '{3, 2, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vals[i]);
      cyc(1, vals[i], 0);
      chk("fill_level", int'(bus.fill_level), i + 1);
    end
    chk("full_valid", int'(bus.out_valid), 1);
    chk("full_head", int'(bus.out_data), 3);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1);
      chk("drain_fill", int'(bus.fill_level), 3 - i);
    end
    chk("drain_valid", int'(bus.out_valid), 0);

    // overflow: fifth beat into a stalled full FIFO is dropped
    vals = '{1, 2, 3, 0, 2};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vals[i]);
      cyc(1, vals[i], 0);
      chk("ovf_pre", int'(bus.overflow), 0);
    end
    cyc(1, vals[4], 0);
    chk("ovf_flag", int'(bus.overflow), 1);
    chk("ovf_fill", int'(bus.fill_level), 4);
    ovf_hold = STICKY ? 1 : 0;
    cyc(0, 0, 0);
    chk("ovf_after", int'(bus.overflow), ovf_hold);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1);
      chk("ovf_drain_fill", int'(bus.fill_level), 3 - i);
      chk("ovf_drain_flag", int'(bus.overflow), ovf_hold);
    end

    // full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i);
      cyc(1, i, 0);
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back((i + 1) % 4);
      cyc(1, (i + 1) % 4, 1);
      chk("fpp_fill", int'(bus.fill_level), 4);
      chk("fpp_overflow", int'(bus.overflow), ovf_hold);
      chk("fpp_valid", int'(bus.out_valid), 1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1);
      chk("fpp_drain_fill", int'(bus.fill_level), 3 - i);
    end

    // reset mid-stream
    vals = '{1, 3, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vals[i]);
      cyc(1, vals[i], 0);
    end
    chk("mid_fill", int'(bus.fill_level), 3);
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_data", int'(bus.out_data), 0);
    chk("mid_rst_fill", int'(bus.fill_level), 0);
    chk("mid_rst_ovf", int'(bus.overflow), 0);
    exp_q.delete();
    ovf_hold = 0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(0, 0, 0);
    exp_q.push_back(2);
    cyc(1, 2, 0);
    chk("post_rst_fill", int'(bus.fill_level), 1);
    chk("post_rst_data", int'(bus.out_data), 2);
    chk("post_rst_valid", int'(bus.out_valid), 1);
    cyc(0, 0, 1);
    chk("post_rst_drain", int'(bus.fill_level), 0);

    // pop attempts while empty
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      chk("empty_fill", int'(bus.fill_level), 0);
      chk("empty_valid", int'(bus.out_valid), 0);
      chk("empty_ovf", int'(bus.overflow), 0);
    end
    exp_q.push_back(1);
    cyc(1, 1, 0);
    chk("empty_next_data", int'(bus.out_data), 1);
    chk("empty_next_fill", int'(bus.fill_level), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonic_v1_15_eth_10g_pa_pg_before_timing_fifo.md
# sonic_v1_15_eth_10g_pa_pg_before_timing_fifo

Avalon-ST timing adapter that bridges a ready-less source (valid-only, no backpressure) to a downstream sink that exerts backpressure through `out_ready`. It sits in the 10G Ethernet pause-frame generator path, ahead of a ready-capable consumer, and absorbs short stalls in a small show-ahead FIFO. It drops beats only on true overflow, and flags every drop.

## Interface
- `DATA_WIDTH`, 2: payload width in bits.
- `DEPTH_LOG2`, 2: log2 of FIFO depth. Depth is `2**DEPTH_LOG2` and must be at least 2.
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream beat present. There is no ready path back to the upstream source.
- `in_data` input `DATA_WIDTH`: upstream payload.
- `out_ready` input 1: downstream can accept a beat this cycle.
- `out_valid` output 1: FIFO holds at least one beat.
- `out_data` output `DATA_WIDTH`: head-of-FIFO payload.
- `fill_level` output `DEPTH_LOG2+1`: current occupancy, 0..`2**DEPTH_LOG2`.
- `overflow` output 1: beat dropped (see Configuration).

## Operation
- Storage: `2**DEPTH_LOG2` entries.
  - Write pointer `wr_ptr` and read pointer `rd_ptr` are `DEPTH_LOG2` bits each and wrap modulo depth.
  - Occupancy counter `count` is `DEPTH_LOG2+1` bits.
- Control is `count`-driven, with two states:
  - EMPTY when `count == 0`.
  - NONEMPTY otherwise.
  - FULL is the sub-condition `count == 2**DEPTH_LOG2`.
- `pop = out_valid & out_ready`.
- `push`:
  - `push = in_valid & (~full | pop)`.
  - A write into a full FIFO is accepted when a pop happens in the same cycle.
- `drop = in_valid & full & ~pop`. A dropped beat is discarded: no pointer or storage change.
- On `push`: `mem[wr_ptr] <= in_data` and `wr_ptr` increments.
- On `pop`: `rd_ptr` increments.
- `count` update:
  - push only: increments by 1.
  - pop only: decrements by 1.
  - push and pop together: unchanged.
- Outputs:
  - `out_valid = (count != 0)`, from registered state.
  - `out_data = mem[rd_ptr]`, show-ahead.
  - `fill_level = count`.
- `out_ready` asserted while `out_valid` is low has no effect. Pop is impossible when empty.
- Beat order is strictly preserved. No beat is duplicated.

## Timing
- Reset (async assert, synchronous deassert handled externally) sets the following:
  - `wr_ptr`, `rd_ptr` and `count` to 0.
  - All `mem` entries to 0.
  - `out_valid` to 0, `out_data` to 0, `fill_level` to 0, `overflow` to 0.
- Reset mid-operation discards all buffered beats. The first cycle after release behaves as EMPTY.
- Latency: a beat written at edge n appears on `out_valid`/`out_data` after edge n, i.e. 1 cycle. There is no combinational path from `in_*` to `out_*`.
- Throughput: 1 beat per cycle sustained while `out_ready` stays high.
- Empty with simultaneous `in_valid` and `out_ready`: push only. `count` goes from 0 to 1.
- Full with simultaneous `in_valid` and `pop`: both occur. `count` stays at max and no drop occurs.
- Pointer wrap: `wr_ptr` and `rd_ptr` roll from `2**DEPTH_LOG2-1` to 0 without a bubble.
- `overflow` is registered. It asserts in the cycle after the dropping edge.

## Configuration
- Macro: `SONIC_PA_PG_TA_OVERFLOW_STICKY_EN`.
- Defined: `overflow` is sticky. It sets on the first `drop` and holds high until `reset_n` is asserted.
- Not defined: `overflow` is a 1-cycle pulse per dropped beat, `overflow <= drop`. Back-to-back drops give a continuously high `overflow`.
- All other behaviour is identical in both builds.

## Test plan
- Pass-through: `out_ready=1`, stream `in_data` 0,1,2,3,0… on consecutive cycles -> same sequence on `out_data` 1 cycle later, `fill_level` constant at 1, `overflow=0`.
- Fill to full: `out_ready=0`, 4 beats 3,2,1,0 (default depth 4) -> `fill_level=4`, `out_valid=1`, `out_data=3`.
  - Then `out_ready=1`, `in_valid=0` -> drain 3,2,1,0 in order, `fill_level` 4→0, `out_valid` low after the last pop.
- Overflow: `out_ready=0`, 5 beats -> 5th beat dropped and `overflow` high the next cycle (pulse build: 1 cycle; sticky build: stays high).
  - Drain yields only the first 4 beats.
- Full with simultaneous push/pop: `count=4`, `in_valid=1`, `out_ready=1` for 6 cycles -> no drops, `fill_level` stays 4, output order matches input order across pointer wrap.
- Reset mid-stream: 3 beats buffered, pulse `reset_n` low asynchronously -> all outputs 0 immediately. After release, the first new beat 2 appears alone with `fill_level=1`.
- Empty pop attempt: `count=0`, `out_ready=1`, `in_valid=0` for 3 cycles -> pointers, `fill_level` and `out_valid` unchanged at 0.
